turn_sequencer: RTL and testbench

- Sequences one player's turn over the card RAM and card-field split.
- Accepts play/buy/end-turn commands from game control. Fetches the 30-bit card word for the named card and splits it into fields.
- Applies the card's effect to the turn resource counters (actions, buys, gold) and emits one draw pulse per card drawn.
- Sits between the game-control FSM, the card RAM and the deck manager.

---
 rtl/turn_sequencer_pkg.sv | 55 +++++
 rtl/turn_sequencer_card_field_latch.sv | 39 +++
 rtl/turn_sequencer.sv | 164 ++++++++++++++++
 tb/tb_turn_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/turn_sequencer_pkg.sv
// Shared card-word layout, kind codes, states and limits
// for the turn sequencer and its card field latch.
package turn_sequencer_pkg;

    localparam int CARD_W = 30;

    localparam int GOLD_MSB   = 29;
    localparam int GOLD_LSB   = 25;
    localparam int BUY_MSB    = 24;
    localparam int BUY_LSB    = 22;
    localparam int ACTION_MSB = 21;
    localparam int ACTION_LSB = 19;
    localparam int DRAW_MSB   = 18;
    localparam int DRAW_LSB   = 16;
    localparam int VP_MSB     = 15;
    localparam int VP_LSB     = 12;
    localparam int COST_MSB   = 11;
    localparam int COST_LSB   = 8;
    localparam int NAME_MSB   = 7;
    localparam int NAME_LSB   = 0;
    localparam int KIND_MSB   = 7;
    localparam int KIND_LSB   = 6;

    localparam logic [1:0] KIND_TREASURE = 2'b00;
    localparam logic [1:0] KIND_VICTORY  = 2'b01;
    localparam logic [1:0] KIND_ACTION   = 2'b10;

    localparam logic [3:0] ACT_MAX  = 4'd15;
    localparam logic [3:0] BUY_MAX  = 4'd15;
    localparam logic [5:0] GOLD_MAX = 6'd63;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        APPLY,
        DRAW,
        DONE,
        REJECT
    } state_e;

    typedef enum logic {
        OP_PLAY,
        OP_BUY
    } op_e;

    typedef struct packed {
        logic [4:0] gold;
        logic [2:0] buy;
        logic [2:0] action;
        logic [2:0] draw;
        logic [3:0] cost;
        logic [1:0] kind;
    } card_t;

endpackage

// File: rtl/turn_sequencer_card_field_latch.sv
// Registers the card word on a load strobe and presents
// the fields the turn logic consumes.
module card_field_latch
    import turn_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [CARD_W-1:0] ram_q,
    output card_t             card
);

    card_t card_d;
    card_t card_q;

    // vp and the low name bits carry no turn effect
    logic unused_bits;
    assign unused_bits = ^{ram_q[VP_MSB:VP_LSB], ram_q[KIND_LSB-1:NAME_LSB]};

    always_comb begin
        card_d = card_q;
        if (load) begin
            card_d.gold   = ram_q[GOLD_MSB:GOLD_LSB];
            card_d.buy    = ram_q[BUY_MSB:BUY_LSB];
            card_d.action = ram_q[ACTION_MSB:ACTION_LSB];
            card_d.draw   = ram_q[DRAW_MSB:DRAW_LSB];
            card_d.cost   = ram_q[COST_MSB:COST_LSB];
            card_d.kind   = ram_q[KIND_MSB:KIND_LSB];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) card_q <= '0;
        else      card_q <= card_d;
    end

    assign card = card_q;

endmodule

// File: rtl/turn_sequencer.sv
// One player's turn: fetch card, apply its effect to the
// action/buy/gold counters, emit draw pulses.
module turn_sequencer
    import turn_sequencer_pkg::*;
#(
    parameter int RAM_LAT  = 1,
    parameter int CARD_AW  = 5,
    parameter int MAX_DRAW = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               play_req,
    input  logic               buy_req,
    input  logic               end_turn,
    input  logic [CARD_AW-1:0] play_id,
    output logic               ram_rd,
    output logic [CARD_AW-1:0] ram_addr,
    input  logic [CARD_W-1:0]  ram_q,
    output logic               busy,
    output logic               draw_pulse,
    output logic               done,
    output logic               reject,
    output logic [3:0]         actions,
    output logic [3:0]         buys,
    output logic [5:0]         gold
);

    localparam logic [1:0] LAT  = 2'(RAM_LAT);
    localparam logic [3:0] MAXD = 4'(MAX_DRAW);

    state_e             state_d, state_q;
    op_e                op_d, op_q;
    logic [1:0]         cnt_d, cnt_q;
    logic [CARD_AW-1:0] id_d, id_q;
    logic [3:0]         drw_d, drw_q;
    logic [3:0]         act_d, act_q;
    logic [3:0]         buy_d, buy_q;
    logic [5:0]         gold_d, gold_q;
    logic               load;
    card_t              card;

    card_field_latch u_latch (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .ram_q (ram_q),
        .card  (card)
    );

    logic       is_act;
    logic [4:0] act_sum;
    logic [4:0] buy_sum;
    logic [6:0] gold_sum;
    logic [3:0] act_sat;
    logic [3:0] buy_sat;
    logic [5:0] gold_sat;
    logic [3:0] draw_n;

    assign is_act   = (card.kind == KIND_ACTION);
    assign act_sum  = {1'b0, act_q} - {4'd0, is_act} + {2'd0, card.action};
    assign buy_sum  = {1'b0, buy_q} + {2'd0, card.buy};
    assign gold_sum = {1'b0, gold_q} + {2'd0, card.gold};
    assign act_sat  = (act_sum > {1'b0, ACT_MAX}) ? ACT_MAX : act_sum[3:0];
    assign buy_sat  = (buy_sum > {1'b0, BUY_MAX}) ? BUY_MAX : buy_sum[3:0];
    assign gold_sat = (gold_sum > {1'b0, GOLD_MAX}) ? GOLD_MAX : gold_sum[5:0];
    assign draw_n   = ({1'b0, card.draw} > MAXD) ? MAXD : {1'b0, card.draw};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        drw_d   = drw_q;
        act_d   = act_q;
        buy_d   = buy_q;
        gold_d  = gold_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (end_turn) begin
                    act_d   = 4'd1;
                    buy_d   = 4'd1;
                    gold_d  = '0;
                    state_d = DONE;
                end else if (buy_req || play_req) begin
                    op_d    = buy_req ? OP_BUY : OP_PLAY;
                    id_d    = play_id;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == LAT) begin
                    load    = 1'b1;
                    state_d = APPLY;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            APPLY: begin
                if (op_q == OP_BUY) begin
                    if (buy_q == '0 || gold_q < {2'd0, card.cost}) begin
                        state_d = REJECT;
                    end else begin
                        buy_d   = buy_q - 4'd1;
                        gold_d  = gold_q - {2'd0, card.cost};
                        state_d = DONE;
                    end
                end else if (!(card.kind == KIND_TREASURE || is_act)) begin
                    state_d = REJECT;
                end else if (is_act && act_q == '0) begin
                    state_d = REJECT;
                end else begin
                    act_d   = act_sat;
                    buy_d   = buy_sat;
                    gold_d  = gold_sat;
                    drw_d   = draw_n;
                    state_d = (draw_n != '0) ? DRAW : DONE;
                end
            end
            DRAW: begin
                if (drw_q == 4'd1) state_d = DONE;
                else               drw_d   = drw_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            REJECT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= OP_PLAY;
            cnt_q   <= '0;
            id_q    <= '0;
            drw_q   <= '0;
            act_q   <= 4'd1;
            buy_q   <= 4'd1;
            gold_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            drw_q   <= drw_d;
            act_q   <= act_d;
            buy_q   <= buy_d;
            gold_q  <= gold_d;
        end
    end

    assign ram_rd     = (state_q == WAIT) && (cnt_q == '0);
    assign ram_addr   = ram_rd ? id_q : '0;
    assign busy       = (state_q == WAIT) || (state_q == APPLY)
                     || (state_q == DRAW);
    assign draw_pulse = (state_q == DRAW);
    assign done       = (state_q == DONE);
    assign reject     = (state_q == REJECT);
    assign actions    = act_q;
    assign buys       = buy_q;
    assign gold       = gold_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed table plus hand sequences for turn_sequencer,
// with a one-cycle-latency card RAM model.
module tb_turn_sequencer;

    logic        clk;
    logic        rst;
    logic        play_req;
    logic        buy_req;
    logic        end_turn;
    logic [4:0]  play_id;
    logic        ram_rd;
    logic [4:0]  ram_addr;
    logic [29:0] ram_q;
    logic        busy;
    logic        draw_pulse;
    logic        done;
    logic        reject;
    logic [3:0]  actions;
    logic [3:0]  buys;
    logic [5:0]  gold;

    logic [29:0] mem [32];

    int n_cmp;
    int n_fail;

    turn_sequencer #(
        .RAM_LAT  (1),
        .CARD_AW  (5),
        .MAX_DRAW (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .play_req   (play_req),
        .buy_req    (buy_req),
        .end_turn   (end_turn),
        .play_id    (play_id),
        .ram_rd     (ram_rd),
        .ram_addr   (ram_addr),
        .ram_q      (ram_q),
        .busy       (busy),
        .draw_pulse (draw_pulse),
        .done       (done),
        .reject     (reject),
        .actions    (actions),
        .buys       (buys),
        .gold       (gold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rd) ram_q <= mem[ram_addr];
    end

    localparam int KT = 0;
    localparam int KV = 1;
    localparam int KA = 2;
    localparam int KR = 3;

    localparam int OPP = 0;
    localparam int OPB = 1;
    localparam int OPE = 2;

    function automatic logic [29:0] card(int g, int b, int a,
                                         int d, int c, int k);
        card = {5'(g), 3'(b), 3'(a), 3'(d), 4'd0, 4'(c), 2'(k), 6'd0};
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse a command after a negedge, then watch until done/reject.
    task automatic run_cmd(input logic p, input logic b, input logic e,
                           input logic [4:0] id,
                           output int lat, output int draws,
                           output int first_d, output int last_d,
                           output int rds, output int res);
        lat = -1; draws = 0; first_d = -1; last_d = -1; rds = 0; res = 0;
        play_req = p; buy_req = b; end_turn = e; play_id = id;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            play_req = 1'b0; buy_req = 1'b0; end_turn = 1'b0;
            if (ram_rd) rds++;
            if (draw_pulse) begin
                draws++;
                if (first_d < 0) first_d = c;
                last_d = c;
            end
            if (done || reject) begin
                lat = c;
                res = {30'd0, done, reject};
                break;
            end
        end
    endtask

    typedef struct {
        int          op;
        logic [29:0] word;
        int          exp_res;
        int          exp_draws;
        int          exp_lat;
        int          ea;
        int          eb;
        int          eg;
    } vec_t;

    vec_t vq[$];

    int lat, draws, fd, ld, rds, res, cnt;

    initial begin
        n_cmp = 0; n_fail = 0;
        play_req = 0; buy_req = 0; end_turn = 0; play_id = '0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_actions", actions, 1);
        check("rst_buys", buys, 1);
        check("rst_gold", gold, 0);
        check("rst_busy", busy, 0);
        check("rst_ram_rd", ram_rd, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_outs", {draw_pulse, done, reject}, 0);
        rst = 1'b1;
        @(negedge clk);

        // res: 2 = done, 1 = reject
        vq.push_back('{OPP, card(3,0,0,0,0,KT), 2, 0, 4, 1, 1, 3});
        vq.push_back('{OPP, card(0,1,2,3,0,KA), 2, 3, 7, 2, 2, 3});
        vq.push_back('{OPP, card(4,0,0,0,0,KV), 1, 0, 4, 2, 2, 3});
        vq.push_back('{OPP, card(5,1,1,1,0,KR), 1, 0, 4, 2, 2, 3});
        vq.push_back('{OPE, '0,                 2, 0, 1, 1, 1, 0});
        vq.push_back('{OPP, card(4,0,0,0,0,KT), 2, 0, 4, 1, 1, 4});
        vq.push_back('{OPB, card(0,0,0,0,5,KV), 1, 0, 4, 1, 1, 4});
        vq.push_back('{OPB, card(0,0,0,0,3,KV), 2, 0, 4, 1, 0, 1});
        vq.push_back('{OPB, card(0,0,0,0,0,KT), 1, 0, 4, 1, 0, 1});
        vq.push_back('{OPP, card(0,0,0,0,0,KA), 2, 0, 4, 0, 0, 1});
        vq.push_back('{OPP, card(2,1,3,2,0,KA), 1, 0, 4, 0, 0, 1});
        vq.push_back('{OPP, card(31,0,0,0,0,KT), 2, 0, 4, 0, 0, 32});
        vq.push_back('{OPP, card(31,0,0,0,0,KT), 2, 0, 4, 0, 0, 63});
        vq.push_back('{OPP, card(31,0,0,0,0,KT), 2, 0, 4, 0, 0, 63});
        vq.push_back('{OPP, card(0,7,7,0,0,KT), 2, 0, 4, 7, 7, 63});
        vq.push_back('{OPP, card(0,7,7,0,0,KT), 2, 0, 4, 14, 14, 63});
        vq.push_back('{OPP, card(0,7,7,0,0,KT), 2, 0, 4, 15, 15, 63});
        vq.push_back('{OPP, card(0,7,7,0,0,KA), 2, 0, 4, 15, 15, 63});
        vq.push_back('{OPP, card(0,0,1,7,0,KA), 2, 7, 11, 15, 15, 63});

        foreach (vq[i]) begin
            mem[i] = vq[i].word;
            run_cmd(vq[i].op == OPP, vq[i].op == OPB, vq[i].op == OPE,
                    5'(i), lat, draws, fd, ld, rds, res);
            check($sformatf("v%0d_result", i), res, vq[i].exp_res);
            check($sformatf("v%0d_latency", i), lat, vq[i].exp_lat);
            check($sformatf("v%0d_draws", i), draws, vq[i].exp_draws);
            if (draws > 0)
                check($sformatf("v%0d_draw_run", i), ld - fd + 1, draws);
            check($sformatf("v%0d_ram_rd", i), rds,
                  (vq[i].op == OPE) ? 0 : 1);
            check($sformatf("v%0d_actions", i), actions, vq[i].ea);
            check($sformatf("v%0d_buys", i), buys, vq[i].eb);
            check($sformatf("v%0d_gold", i), gold, vq[i].eg);
            @(negedge clk);
        end

        // end_turn beats a simultaneous play_req
        mem[20] = card(9,0,0,0,0,KT);
        run_cmd(1'b1, 1'b0, 1'b1, 5'd20, lat, draws, fd, ld, rds, res);
        check("et_result", res, 2);
        check("et_latency", lat, 1);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ram_rd || busy) cnt++;
        end
        check("et_no_play", rds + cnt, 0);
        check("et_actions", actions, 1);
        check("et_buys", buys, 1);
        check("et_gold", gold, 0);

        // play_req while busy is dropped
        mem[21] = card(1,0,0,0,0,KT);
        mem[22] = card(10,0,0,0,0,KT);
        play_req = 1'b1; play_id = 5'd21;
        @(negedge clk);
        play_req = 1'b0;
        @(negedge clk);
        play_req = 1'b1; play_id = 5'd22;
        @(negedge clk);
        play_req = 1'b0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("busy_done_count", cnt, 1);
        check("busy_gold", gold, 1);
        check("busy_idle", busy, 0);

        // reset during DRAW after the first pulse
        mem[23] = card(5,2,3,5,0,KA);
        play_req = 1'b1; play_id = 5'd23;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            play_req = 1'b0;
            if (draw_pulse) begin
                cnt = 1;
                break;
            end
        end
        check("rd_first_pulse", cnt, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (draw_pulse || done) cnt++;
            @(negedge clk);
        end
        check("rd_no_more_pulses", cnt, 0);
        check("rd_actions", actions, 1);
        check("rd_buys", buys, 1);
        check("rd_gold", gold, 0);
        check("rd_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
